spi_chain_responder: RTL and testbench
======================================

// Module: spi_chain_responder
// PURPOSE
//  SPI responder (slave end) for the daisy-chain bus driven by the team's spi_master.
//  Runs entirely in the clk domain and oversamples sclk, ss and mosi.
//  Supports all four CPOL/CPHA modes and shifts MSB first.
//  Its shift register forms one chain stage: received bits pass out on miso one byte later.
//  Parallel tx load and rx valid hooks connect it to local logic.
// PARAMETERS
//  DATA_W   8   frame/shift-register width in bits
// PORTS
//  clk        in   1        system clock; must be >= 8x sclk frequency
//  rst        in   1        synchronous, active-low reset
//  sclk       in   1        SPI clock from master/previous stage (async to clk)
//  ss         in   1        chip select, active-low (async)
//  mosi       in   1        serial in (master mosi or upstream miso)
//  miso       out  1        serial out (to master miso or downstream mosi)
//  mode       in   2        {CPOL,CPHA}; only sampled while IDLE
//  tx_data    in   DATA_W   byte to present on next frame
//  tx_load    in   1        write strobe for tx_data
//  tx_ready   out  1        high when tx_load will be accepted (IDLE only)
//  rx_data    out  DATA_W   last complete received byte
//  rx_valid   out  1        1-cycle pulse when rx_data updates
//  busy       out  1        high while in ACTIVE
//  frame_err  out  1        1-cycle pulse when ss deasserts mid-byte
// BEHAVIOUR
//  Reset: all outputs, tx_hold, shreg, bit_cnt, edge flops = 0. mode_q = 0. State = IDLE.
//  Input sync: sclk, ss and mosi each pass 2 flops. Edge detect adds 1 flop.
//   Pin-to-action latency is 3 clk.
//  Edges: lead = sclk leaves CPOL level; trail = sclk returns to CPOL level.
//  FSM IDLE -> ACTIVE on synced ss fall:
//   - shreg <= tx_hold; mode_q <= mode; bit_cnt <= 0.
//   - If tx_load is high in the same cycle, tx_data bypasses tx_hold into shreg and is also stored.
//  ACTIVE, CPHA=0:
//   - sample mosi into shreg[0] on lead edge, after shifting shreg left by 1.
//   - miso is updated to shreg[DATA_W-1] on trail edge; the first bit appears at ss fall.
//  ACTIVE, CPHA=1:
//   - miso <= shreg[DATA_W-1] on lead edge.
//   - shift/sample on trail edge.
//  bit_cnt increments on each sample edge and wraps DATA_W-1 -> 0.
//   On the wrap cycle: rx_data <= new shreg value; rx_valid = 1 for 1 clk.
//   shreg is NOT reloaded, so the next byte out equals the byte just received (chain pass-through).
//  ACTIVE -> IDLE on synced ss rise:
//   - If bit_cnt != 0: frame_err pulse, partial byte discarded, rx_data unchanged.
//   - bit_cnt <= 0.
//  A sample edge coincident with ss rise is ignored.
//  miso is driven 0 in IDLE; no tri-state.
//  tx_ready = (state==IDLE). tx_load while ACTIVE is ignored and tx_hold is unchanged.
//  tx_hold persists across frames; re-sent if not reloaded.
//  mode change while ACTIVE has no effect until the next frame.
//  rst low mid-frame: immediate return to IDLE, all outputs to reset values, no frame_err.
// STRUCTURE
//  spi_pkg: typedef enum logic {IDLE, ACTIVE} spi_state_e;
//   typedef struct packed {logic cpol; logic cpha;} spi_mode_t; localparam SPI_DATA_W = 8.
//  Sub-module spi_sync_edge: 2-flop synchronizer plus rise/fall pulse outputs.
//   One instance each for sclk and ss; mosi is synchronized only.
//  Top: FSM, bit counter, shift register, tx_hold.
// TESTING
//  1) mode 0, tx_load 0xA5 in IDLE; master sends 0x3C -> miso 1,0,1,0,0,1,0,1;
//     rx_data=0x3C; one rx_valid pulse; busy falls 3 clk after ss rise.
//  2) mode 3 (CPOL=1,CPHA=1): tx 0x81, master sends 0x7E -> miso 0x81 MSB first; rx_data=0x7E.
//  3) 16-bit frame, tx 0x11, master sends 0xC3,0x5A -> miso 0x11 then 0xC3;
//     rx_valid twice; final rx_data=0x5A.
//  4) ss rises after 5 bits -> frame_err pulse; no rx_valid; rx_data keeps prior value.
//  5) tx_load 0xFF while busy -> ignored; tx_ready=0; next frame still sends the old tx_hold.
//  6) rst low at bit 4 -> outputs 0, state IDLE; next full frame completes normally.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and widths for the SPI chain responder
package spi_pkg;
    localparam int SPI_DATA_W = 8;
    typedef enum logic {IDLE, ACTIVE} spi_state_e;
    typedef struct packed {logic cpol; logic cpha;} spi_mode_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer with registered rise/fall detection
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic s1, s3;
    always_ff @(posedge clk) begin
        if (!rst) {s1, q, s3} <= '0;
        else      {s1, q, s3} <= {d, s1, q};
    end
    assign rise = q & ~s3;
    assign fall = ~q & s3;
endmodule

// File: rtl/spi_chain_responder.sv
// spi_chain_responder: oversampled SPI responder forming one daisy-chain shift stage
module spi_chain_responder
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              frame_err
);
    localparam int CW = $clog2(DATA_W);
    spi_state_e state, state_next;
    spi_mode_t mode_q;
    logic [DATA_W-1:0] shreg, tx_hold, shreg_nx, first;
    logic [CW-1:0] bit_cnt;
    logic sclk_s, sclk_rise, sclk_fall, ss_s, ss_rise, ss_fall;
    logic mosi_1, mosi_s, lead, trail, samp, shout, wrap;
    spi_sync_edge u_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge u_ss (.clk(clk), .rst(rst), .d(ss), .q(ss_s), .rise(ss_rise), .fall(ss_fall));
    assign lead = mode_q.cpol ? sclk_fall : sclk_rise;
    assign trail = mode_q.cpol ? sclk_rise : sclk_fall;
    assign samp = mode_q.cpha ? trail : lead;
    assign shout = mode_q.cpha ? lead : trail;
    assign wrap = bit_cnt == CW'(DATA_W - 1);
    assign shreg_nx = {shreg[DATA_W-2:0], mosi_s};
    assign first = tx_load ? tx_data : tx_hold;
    assign tx_ready = state == IDLE;
    assign busy = state == ACTIVE;
    always_comb begin
        state_next = state;
        state_next = (state == IDLE) ? (ss_fall ? ACTIVE : IDLE) : (ss_rise ? IDLE : ACTIVE);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            mode_q    <= '0;
            {mosi_1, mosi_s} <= '0;
            shreg     <= '0;
            tx_hold   <= '0;
            bit_cnt   <= '0;
            miso      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            {mosi_1, mosi_s} <= {mosi, mosi_1};
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (state == IDLE) begin
                miso <= 1'b0;
                if (tx_load) tx_hold <= tx_data;
                if (ss_fall) begin
                    shreg   <= first;
                    mode_q  <= spi_mode_t'(mode);
                    bit_cnt <= '0;
                    miso    <= mode[0] ? 1'b0 : first[DATA_W-1];
                end
            end else if (ss_rise) begin
                // a sample edge landing with ss rise is dropped with the partial byte
                frame_err <= bit_cnt != '0;
                bit_cnt   <= '0;
                miso      <= 1'b0;
            end else begin
                if (samp) begin
                    shreg   <= shreg_nx;
                    bit_cnt <= wrap ? '0 : bit_cnt + CW'(1);
                    if (wrap) begin
                        rx_data  <= shreg_nx;
                        rx_valid <= 1'b1;
                    end
                end
                if (shout) miso <= shreg[DATA_W-1];
            end
        end
    end
endmodule

// File: tb/tb_spi_chain_responder.sv
// tb_spi_chain_responder: directed SPI frames with queued expectations and decoupled monitors
module tb_spi_chain_responder;
    localparam int H = 50;
    logic clk = 0, rst = 0, sclk = 0, ss = 1, mosi = 0, miso;
    logic [1:0] mode = 0;
    logic [7:0] tx_data = 0, rx_data;
    logic tx_load = 0, tx_ready, rx_valid, busy, frame_err;
    logic miso_obs;
    int npass = 0, ntot = 0, ferr_exp = 0;
    logic [7:0] rx_q[$];
    logic miso_q[$];
    event ms;

    spi_chain_responder dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
        .mode(mode), .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        ntot++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (rst && rx_valid) begin
            if (rx_q.size() == 0) fail("rx_unexpected");
            else chk("rx_data", rx_data, rx_q.pop_front());
        end
        if (rst && frame_err) begin
            if (ferr_exp == 0) fail("frame_err_unexpected");
            else begin
                ferr_exp--;
                chk("frame_err", frame_err, 1);
            end
        end
    end

    always @(ms) begin
        if (miso_q.size() == 0) fail("miso_unexpected");
        else chk("miso_bit", miso_obs, miso_q.pop_front());
    end

    task automatic load(input logic [7:0] v);
        chk("tx_ready_idle", tx_ready, 1);
        tx_data = v;
        tx_load = 1;
        #10;
        tx_load = 0;
    endtask

    task automatic xfer(input logic [1:0] m, input int n, input logic [63:0] mo,
                        input logic [63:0] exp, input int abort_at, input bit ld_mid);
        for (int i = 0; i < ((abort_at < 0) ? n : abort_at); i++) miso_q.push_back(exp[n-1-i]);
        mode = m;
        sclk = m[1];
        #200;
        ss = 0;
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                rst = 0;
                #40;
                chk("rst_busy", busy, 0);
                chk("rst_tx_ready", tx_ready, 1);
                chk("rst_miso", miso, 0);
                chk("rst_rx_data", rx_data, 0);
                chk("rst_flags", {rx_valid, frame_err}, 0);
                rst = 1;
                ss = 1;
                sclk = m[1];
                #200;
                return;
            end
            if (ld_mid && i == 3) begin
                chk("tx_ready_busy", tx_ready, 0);
                tx_data = 8'hFF;
                tx_load = 1;
                #10;
                tx_load = 0;
            end
            if (!m[0]) begin
                mosi = mo[n-1-i];
                #H;
                sclk = ~sclk;
                miso_obs = miso;
                ->ms;
                #H;
                sclk = ~sclk;
            end else begin
                #H;
                sclk = ~sclk;
                mosi = mo[n-1-i];
                #H;
                sclk = ~sclk;
                miso_obs = miso;
                ->ms;
            end
        end
        #H;
        ss = 1;
        #20;
        chk("busy_hold", busy, 1);
        #10;
        chk("busy_fall", busy, 0);
        #100;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        #40;
        chk("reset_busy", busy, 0);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_miso", miso, 0);
        rst = 1;
        #100;
        load(8'hA5);
        rx_q.push_back(8'h3C);
        xfer(2'd0, 8, 64'h3C, 64'hA5, -1, 0);
        load(8'h81);
        rx_q.push_back(8'h7E);
        xfer(2'd3, 8, 64'h7E, 64'h81, -1, 0);
        load(8'h11);
        rx_q.push_back(8'hC3);
        rx_q.push_back(8'h5A);
        xfer(2'd0, 16, 64'hC35A, 64'h11C3, -1, 0);
        ferr_exp = 1;
        xfer(2'd0, 5, 64'b10110, 64'b00010, -1, 0);
        chk("rx_data_kept", rx_data, 8'h5A);
        rx_q.push_back(8'h96);
        xfer(2'd1, 8, 64'h96, 64'h11, -1, 1);
        rx_q.push_back(8'h0F);
        xfer(2'd2, 8, 64'h0F, 64'h11, -1, 0);
        load(8'h6B);
        xfer(2'd0, 8, 64'hFF, 64'h6B, 4, 0);
        load(8'hC6);
        rx_q.push_back(8'h99);
        xfer(2'd0, 8, 64'h99, 64'hC6, -1, 0);
        #200;
        chk("rx_queue_drained", rx_q.size(), 0);
        chk("miso_queue_drained", miso_q.size(), 0);
        chk("frame_err_seen", ferr_exp, 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
